// File: rtl/wb_stage.sv
// MEM/WB pipeline register with write-back formatting (ALU, extended load, link),
// misaligned-load detection and a retired-instruction counter.
module wb_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        M_Valid,
    input  logic [31:0] M_PC,
    input  logic        M_RegWrite,
    input  logic [1:0]  M_RegDst,
    input  logic [1:0]  M_WbSel,
    input  logic [2:0]  M_LoadType,
    input  logic [4:0]  M_Rt,
    input  logic [4:0]  M_Rd,
    input  logic [31:0] M_AluOut,
    input  logic [31:0] M_MemData,
    output logic [4:0]  WA,
    output logic [31:0] WData,
    output logic        RegWrite,
    output logic [31:0] W_PC,
    output logic        W_Valid,
    output logic        AdEL,
    output logic [31:0] InstrCount
);

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;
    localparam logic [1:0] DST_NONE = 2'b11;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        regwrite;
        logic [1:0]  regdst;
        logic [1:0]  wbsel;
        logic [2:0]  loadtype;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] aluout;
        logic [31:0] memdata;
    } w_reg_t;

    w_reg_t      w_q;
    logic [31:0] instr_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            w_q <= '0;
        end else if (!Stall) begin
            w_q.valid    <= M_Valid;
            w_q.pc       <= M_PC;
            w_q.regwrite <= M_RegWrite;
            w_q.regdst   <= M_RegDst;
            w_q.wbsel    <= M_WbSel;
            w_q.loadtype <= M_LoadType;
            w_q.rt       <= M_Rt;
            w_q.rd       <= M_Rd;
            w_q.aluout   <= M_AluOut;
            w_q.memdata  <= M_MemData;
        end
    end

    // An instruction retires when it leaves W: either replaced (no stall) or
    // squashed by a flush. A stalled instruction is counted only on its way out.
    always_ff @(posedge Clk) begin
        if (Reset)
            instr_cnt <= '0;
        else if (w_q.valid && (!Stall || Flush))
            instr_cnt <= instr_cnt + 32'd1;
    end

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic        is_word_load;
    logic        is_half_load;
    logic        misaligned;
    logic [4:0]  dest;
    logic [31:0] wb_val;

    always_comb begin
        byte_lane = w_q.memdata[7:0];
        case (w_q.aluout[1:0])
            2'd0: byte_lane = w_q.memdata[7:0];
            2'd1: byte_lane = w_q.memdata[15:8];
            2'd2: byte_lane = w_q.memdata[23:16];
            2'd3: byte_lane = w_q.memdata[31:24];
            default: byte_lane = w_q.memdata[7:0];
        endcase
        half_lane = w_q.aluout[1] ? w_q.memdata[31:16] : w_q.memdata[15:0];
    end

    // Unlisted load encodings behave as lw for both data and alignment checks.
    always_comb begin
        load_val     = w_q.memdata;
        is_word_load = 1'b0;
        is_half_load = 1'b0;
        case (w_q.loadtype)
            LD_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
            LD_LBU:  load_val = {24'd0, byte_lane};
            LD_LH: begin
                load_val     = {{16{half_lane[15]}}, half_lane};
                is_half_load = 1'b1;
            end
            LD_LHU: begin
                load_val     = {16'd0, half_lane};
                is_half_load = 1'b1;
            end
            default: begin
                load_val     = w_q.memdata;
                is_word_load = 1'b1;
            end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if (w_q.valid && w_q.wbsel == SEL_LOAD) begin
            if (is_word_load && w_q.aluout[1:0] != 2'b00)
                misaligned = 1'b1;
            else if (is_half_load && w_q.aluout[0])
                misaligned = 1'b1;
        end
    end

    always_comb begin
        dest = 5'd0;
        case (w_q.regdst)
            DST_RT:   dest = w_q.rt;
            DST_RD:   dest = w_q.rd;
            DST_RA:   dest = 5'd31;
            DST_NONE: dest = 5'd0;
            default:  dest = 5'd0;
        endcase
    end

    // Reserved wbsel falls through to the ALU result.
    always_comb begin
        wb_val = w_q.aluout;
        case (w_q.wbsel)
            SEL_LOAD: wb_val = load_val;
            SEL_LINK: wb_val = w_q.pc + 32'd8;
            default:  wb_val = w_q.aluout;
        endcase
    end

    assign WA         = dest;
    assign WData      = wb_val;
    assign RegWrite   = w_q.valid && w_q.regwrite && (w_q.regdst != DST_NONE) &&
                        (dest != 5'd0) && !misaligned;
    assign W_PC       = w_q.pc;
    assign W_Valid    = w_q.valid;
    assign AdEL       = misaligned;
    assign InstrCount = instr_cnt;

endmodule
